// File: rtl/sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_arb : N-channel arbiter/sequencer sharing one async 16-bit SRAM/PSRAM.
// Optional macro SRAM_ARB_TURN_EN inserts a turnaround cycle after writes. Rev 1.0
// ----------------------------------------------------------------------------
module sram_arb #(
  parameter int CH       = 3,
  parameter int AW       = 23,
  parameter int MEM_TIME = 4,
  parameter int PRIO     = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CH-1:0]    ch_req,
  input  logic [CH*AW-1:0] ch_addr,
  input  logic [CH*16-1:0] ch_dati,
  input  logic [CH*2-1:0]  ch_we,
  output logic [CH-1:0]    ch_ack,
  output logic [15:0]      ch_dato,
  output logic [AW-2:0]    mem_addr,
  output logic [15:0]      mem_dati,
  input  logic [15:0]      mem_dato,
  output logic [1:0]       mem_we,
  output logic             mem_oe,
  output logic             mem_ce
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = (MEM_TIME > 1) ? $clog2(MEM_TIME) : 1;
  localparam logic [CW-1:0] c_CNT_INIT = CW'(MEM_TIME - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_we;

  logic [IW-1:0] w_win;
  logic          w_any;
  logic [AW-2:0] w_addr;
  logic [15:0]   w_dat;
  logic [1:0]    w_wen;
  logic [CH-1:0] w_ack1;
  logic [CH-1:0] w_lsb;
  logic          w_unused;

  // Round-robin search starts at r_ptr (one past the last grant); fixed mode starts at 0.
  always_comb begin
    int v_i;
    v_i   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int off = 0; off < CH; off++) begin
      v_i = (PRIO != 0) ? off : (int'(r_ptr) + off);
      if (v_i >= CH) v_i = v_i - CH;
      for (int j = 0; j < CH; j++) begin
        if (j == v_i && !w_any && ch_req[j]) begin
          w_any = 1'b1;
          w_win = IW'(j);
        end
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_dat  = '0;
    w_wen  = '0;
    w_ack1 = '0;
    w_lsb  = '0;
    for (int j = 0; j < CH; j++) begin
      if (w_win == IW'(j)) begin
        w_addr = ch_addr[j*AW+1 +: AW-1];
        w_dat  = ch_dati[j*16 +: 16];
        w_wen  = ch_we[j*2 +: 2];
      end
      w_ack1[j] = (r_idx == IW'(j));
      w_lsb[j]  = ch_addr[j*AW];
    end
  end

  // Byte-address bit 0 has no meaning on a 16-bit chip.
  assign w_unused = ^w_lsb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_we     <= '0;
      ch_ack   <= '0;
      ch_dato  <= '0;
      mem_addr <= '0;
      mem_dati <= '0;
      mem_we   <= '0;
      mem_oe   <= 1'b0;
      mem_ce   <= 1'b0;
    end else begin
      ch_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx    <= w_win;
            r_we     <= w_wen;
            r_cnt    <= c_CNT_INIT;
            r_ptr    <= (w_win == IW'(CH - 1)) ? '0 : w_win + 1'b1;
            mem_addr <= w_addr;
            mem_dati <= w_dat;
            mem_we   <= w_wen;
            mem_oe   <= (w_wen == 2'b00);
            mem_ce   <= 1'b1;
            r_state  <= S_ACC;
          end
        end
        S_ACC: begin
          if (r_cnt == '0) begin
            if (r_we == 2'b00) ch_dato <= mem_dato;
            mem_ce  <= 1'b0;
            mem_oe  <= 1'b0;
            mem_we  <= 2'b00;
            ch_ack  <= w_ack1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
`ifdef SRAM_ARB_TURN_EN
          r_state <= (r_we != 2'b00) ? S_TURN : S_IDLE;
`else
          r_state <= S_IDLE;
`endif
        end
        S_TURN:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arb.sv
`default_nettype none
// tb_sram_arb : directed vectors, multi-cycle corner sequences and a randomized
// transaction-level reference model for sram_arb.
module tb_sram_arb;
  localparam int CH = 3;
  localparam int AW = 23;
  localparam int MT = 4;
`ifdef SRAM_ARB_TURN_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif

  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0]    req, req_p;
  logic [CH*AW-1:0] addr;
  logic [CH*16-1:0] dati;
  logic [CH*2-1:0]  we;
  logic [CH-1:0]    ack, p_ack;
  logic [15:0]      dato, p_dato, m_dati, p_mdati, m_dato, p_mdato;
  logic [AW-2:0]    m_addr, p_maddr;
  logic [1:0]       m_we, p_mwe;
  logic             m_oe, m_ce, p_moe, p_mce;
  logic [15:0]      sram [16];

  assign m_dato  = sram[m_addr[3:0]];
  assign p_mdato = sram[p_maddr[3:0]];

  sram_arb #(.CH(CH), .AW(AW), .MEM_TIME(MT), .PRIO(0)) dut (
    .clk(clk), .rstn(rstn), .ch_req(req), .ch_addr(addr), .ch_dati(dati), .ch_we(we),
    .ch_ack(ack), .ch_dato(dato), .mem_addr(m_addr), .mem_dati(m_dati), .mem_dato(m_dato),
    .mem_we(m_we), .mem_oe(m_oe), .mem_ce(m_ce));

  sram_arb #(.CH(CH), .AW(AW), .MEM_TIME(MT), .PRIO(1)) dut_p (
    .clk(clk), .rstn(rstn), .ch_req(req_p), .ch_addr(addr), .ch_dati(dati), .ch_we(we),
    .ch_ack(p_ack), .ch_dato(p_dato), .mem_addr(p_maddr), .mem_dati(p_mdati), .mem_dato(p_mdato),
    .mem_we(p_mwe), .mem_oe(p_moe), .mem_ce(p_mce));

  // Chip model: contents reload during reset; byte lanes follow we[1]=low, we[0]=high.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) sram[i] = 16'hBEED + 16'(i);
    end else if (m_ce) begin
      if (m_we[1]) sram[m_addr[3:0]][7:0]  = m_dati[7:0];
      if (m_we[0]) sram[m_addr[3:0]][15:8] = m_dati[15:8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, grant chosen by the arbitration rule.
  bit            model_on;
  int            ecnt, free_at, g_edge, g_ch, rr, pick, widx;
  bit            g_act;
  logic [AW-1:0] g_addr;
  logic [1:0]    g_we;
  logic [15:0]   g_dat, g_exp;
  logic [15:0]   refm [16];

  always @(posedge clk) begin
    if (!rstn) begin
      ecnt = 0; free_at = 0; rr = 0; g_act = 0;
      for (int i = 0; i < 16; i++) refm[i] = 16'hBEED + 16'(i);
    end else if (model_on) begin
      ecnt++;
      if (g_act && ecnt > g_edge + MT) g_act = 0;
      if (!g_act && ecnt >= free_at && req != '0) begin
        pick = -1;
        for (int off = 0; off < CH; off++)
          if (pick < 0 && req[(rr + off) % CH]) pick = (rr + off) % CH;
        g_ch   = pick;
        g_addr = addr[pick*AW +: AW];
        g_we   = we[pick*2 +: 2];
        g_dat  = dati[pick*16 +: 16];
        rr     = (pick + 1) % CH;
        widx   = int'(g_addr[4:1]);
        if (g_we == 2'b00) g_exp = refm[widx];
        if (g_we[1]) refm[widx][7:0]  = g_dat[7:0];
        if (g_we[0]) refm[widx][15:8] = g_dat[15:8];
        g_edge  = ecnt;
        free_at = ecnt + MT + 2 + ((g_we != 2'b00) ? TURN : 0);
        g_act   = 1;
      end
    end
  end

  typedef struct {
    int            ch;
    logic [AW-1:0] a;
    logic [1:0]    w;
    logic [15:0]   d;
    logic [AW-2:0] xaddr;
    logic [15:0]   xdato;
  } vec_t;
  vec_t tbl [7];

  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [1:0] w, input logic [15:0] d);
    addr[c*AW +: AW] = a;
    we[c*2 +: 2]     = w;
    dati[c*16 +: 16] = d;
  endtask

  task automatic run_vec(input vec_t v);
    int ce_n, ok_n, ack_at, ack_n;
    ce_n = 0; ok_n = 0; ack_at = -1; ack_n = 0;
    set_ch(v.ch, v.a, v.w, v.d);
    req[v.ch] = 1'b1;
    for (int n = 1; n <= MT + 3; n++) begin
      @(negedge clk);
      if (m_ce) begin
        ce_n++;
        if (m_addr == v.xaddr && m_oe == (v.w == 2'b00) && m_we == v.w && (v.w == 2'b00 || m_dati == v.d))
          ok_n++;
      end
      if (ack != '0) begin
        ack_n++;
        chk("vec_ack_onehot", 32'(ack), 32'(1) << v.ch);
        if (ack[v.ch]) ack_at = n;
        req[v.ch] = 1'b0;
        if (v.w == 2'b00) chk("vec_dato", 32'(dato), 32'(v.xdato));
      end
    end
    chk("vec_ce_cycles", ce_n, MT);
    chk("vec_strobes", ok_n, MT);
    chk("vec_ack_latency", ack_at, MT + 1);
    chk("vec_ack_count", ack_n, 1);
  endtask

  task automatic new_fields(input int c);
    logic [1:0] w;
    w = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(3));
    set_ch(c, AW'($urandom_range(31)), w, 16'($urandom));
  endtask

  int seen, last_t, t, k, st, gap, gap_res, cnt_a, cnt_c, r;
  logic [CH-1:0] pend, exp_ack;
  bit in_win;

  initial begin
    tbl[0] = '{0, 23'h000124, 2'b00, 16'h0000, 22'h000092, 16'hBEEF};
    tbl[1] = '{1, 23'h000010, 2'b10, 16'h1234, 22'h000008, 16'h0000};
    tbl[2] = '{2, 23'h000011, 2'b00, 16'h0000, 22'h000008, 16'hBE34};
    tbl[3] = '{0, 23'h7FFFFE, 2'b11, 16'hA55A, 22'h3FFFFF, 16'h0000};
    tbl[4] = '{1, 23'h7FFFFF, 2'b00, 16'h0000, 22'h3FFFFF, 16'hA55A};
    tbl[5] = '{2, 23'h000004, 2'b01, 16'h7700, 22'h000002, 16'h0000};
    tbl[6] = '{0, 23'h000005, 2'b00, 16'h0000, 22'h000002, 16'h77EF};

    model_on = 0; rstn = 1'b0; req = '0; req_p = '0; addr = '0; dati = '0; we = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce", 32'(m_ce), 0);
    chk("rst_oe", 32'(m_oe), 0);
    chk("rst_we", 32'(m_we), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_dati", 32'(m_dati), 0);
    chk("rst_dato", 32'(dato), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ce", 32'(m_ce), 0);
    chk("idle_ack", 32'(ack), 0);
    chk("idle_addr", 32'(m_addr), 0);

    // Reset in the middle of an access.
    set_ch(0, 23'h000124, 2'b00, 16'h0);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_pre_ce", 32'(m_ce), 1);
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("abort_ce", 32'(m_ce), 0);
    chk("abort_oe", 32'(m_oe), 0);
    chk("abort_we", 32'(m_we), 0);
    chk("abort_ack", 32'(ack), 0);
    req[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cnt_a = 0; cnt_c = 0;
    for (int n = 0; n < MT + 4; n++) begin
      @(negedge clk);
      if (ack != '0) cnt_a++;
      if (m_ce) cnt_c++;
    end
    chk("abort_no_ack", cnt_a, 0);
    chk("abort_no_ce", cnt_c, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Round-robin: all channels keep re-requesting.
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    we = '0; req = '1; pend = '0; seen = 0; last_t = 0; t = 0;
    for (int n = 0; n < 80 && seen < 6; n++) begin
      @(negedge clk); t++;
      req = req | pend; pend = '0;
      if (ack != '0) begin
        k = -1;
        for (int i = CH - 1; i >= 0; i--) if (ack[i]) k = i;
        chk("rr_order", k, seen % 3);
        if (seen > 0) chk("rr_spacing", t - last_t, MT + 2);
        last_t = t; req[k] = 1'b0; pend[k] = 1'b1; seen++;
      end
    end
    chk("rr_count", seen, 6);
    req = '0;

    // Fixed priority: ch0 keeps winning, then ch1 once ch0 stops asking.
    req_p = '1; pend = '0; seen = 0; last_t = 0; t = 0;
    for (int n = 0; n < 80 && seen < 4; n++) begin
      @(negedge clk); t++;
      req_p = req_p | pend; pend = '0;
      if (p_ack != '0) begin
        k = -1;
        for (int i = CH - 1; i >= 0; i--) if (p_ack[i]) k = i;
        chk("prio_order", k, (seen < 3) ? 0 : 1);
        if (seen > 0) chk("prio_spacing", t - last_t, MT + 2);
        last_t = t; req_p[k] = 1'b0;
        if (!(k == 0 && seen == 2)) pend[k] = 1'b1;
        seen++;
      end
    end
    chk("prio_count", seen, 4);
    req_p = '0;

    // Write followed by a pending read: strobe-free gap between the two windows.
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    set_ch(0, 23'h000020, 2'b11, 16'h5A5A);
    set_ch(1, 23'h000002, 2'b00, 16'h0);
    req[0] = 1'b1; req[1] = 1'b1;
    st = 0; gap = 0; gap_res = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack[0]) req[0] = 1'b0;
      if (ack[1]) req[1] = 1'b0;
      if (st == 0 && m_ce) begin
        st = 1;
        chk("turn_first_is_write", 32'(m_we), 32'(2'b11));
      end else if (st == 1 && !m_ce) begin
        st = 2; gap = 1;
      end else if (st == 2) begin
        if (m_ce) begin gap_res = gap; st = 3; end
        else gap++;
      end
    end
    chk("turn_gap", gap_res, 2 + TURN);
    req = '0;

    // Randomized traffic against the reference model.
    rstn = 1'b0; repeat (2) @(negedge clk);
    rstn = 1'b1; model_on = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      in_win  = g_act && ecnt >= g_edge && ecnt < g_edge + MT;
      exp_ack = '0;
      if (g_act && ecnt == g_edge + MT) exp_ack[g_ch] = 1'b1;
      chk("rnd_ack", 32'(ack), 32'(exp_ack));
      chk("rnd_ce", 32'(m_ce), 32'(in_win));
      chk("rnd_oe", 32'(m_oe), 32'(in_win && g_we == 2'b00));
      chk("rnd_we", 32'(m_we), in_win ? 32'(g_we) : 32'(0));
      if (in_win) begin
        chk("rnd_addr", 32'(m_addr), 32'(g_addr[AW-1:1]));
        if (g_we != 2'b00) chk("rnd_dati", 32'(m_dati), 32'(g_dat));
      end
      if (exp_ack != '0 && g_we == 2'b00) chk("rnd_dato", 32'(dato), 32'(g_exp));
      for (int i = 0; i < CH; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            new_fields(i);
            req[i] = 1'b1;
          end
        end else if (!(g_act && g_ch == i)) begin
          r = int'($urandom_range(15));
          if (r == 0) req[i] = 1'b0;
          else if (r < 3) new_fields(i);
        end
      end
    end
    model_on = 0;
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
